mem_cache_ctrl: RTL and testbench

//  - Sequences every MEM-stage data access through a 2-way set-associative, write-through, no-write-allocate cache in front of the SRAM controller.
//  - Drives ready; the top level uses freeze = ~ready on the MEM-stage pipeline register and on all earlier stages.
//  - A hit completes in the request cycle. A miss or any write holds ready low until the SRAM side acknowledges.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_set_array.sv | 52 +++++
 rtl/mem_cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the MEM-stage data cache controller.
package cache_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned INDEX_W   = 6;
   localparam int unsigned TAG_W     = 10;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned LINE_W    = 64;

   // Byte-address slices: word offset, set index, tag
   localparam int unsigned OFF_BIT   = 2;
   localparam int unsigned INDEX_LSB = 3;
   localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/cache_set_array.sv
// One way of the cache: valid/tag/two-word line per set, async read, sync write.
module cache_set_array #(
   parameter int unsigned INDEX_W = 6,
   parameter int unsigned TAG_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] i_index,
   input  logic               i_line_we,
   input  logic [1:0]         i_word_we,
   input  logic [TAG_W-1:0]   i_tag,
   input  logic [63:0]        i_line,
   output logic               o_valid,
   output logic [TAG_W-1:0]   o_tag,
   output logic [63:0]        o_line
);
   import cache_pkg::*;

   localparam int unsigned SETS = 1 << INDEX_W;

   logic [SETS-1:0]   r_valid;
   logic [TAG_W-1:0]  r_tag   [SETS];
   logic [WORD_W-1:0] r_word0 [SETS];
   logic [WORD_W-1:0] r_word1 [SETS];

   // Valid bits: cleared on reset, set by a line fill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_line_we) begin
         r_valid[i_index] <= 1'b1;
      end
   end

   // Tag and data storage (not reset): tag with the line fill, words by enable
   always_ff @(posedge clk) begin
      if (i_line_we) begin
         r_tag[i_index] <= i_tag;
      end
      if (i_word_we[0]) begin
         r_word0[i_index] <= i_line[31:0];
      end
      if (i_word_we[1]) begin
         r_word1[i_index] <= i_line[63:32];
      end
   end

   assign o_valid = r_valid[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_line  = {r_word1[i_index], r_word0[i_index]};

endmodule

// File: rtl/mem_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache controller.
module mem_cache_ctrl #(
   parameter int unsigned INDEX_W = cache_pkg::INDEX_W,
   parameter int unsigned TAG_W   = cache_pkg::TAG_W,
   parameter int unsigned ADDR_W  = cache_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              sram_r_en,
   output logic              sram_w_en,
   output logic [ADDR_W-1:0] sram_address,
   output logic [31:0]       sram_wdata,
   input  logic [63:0]       sram_rdata,
   input  logic              sram_ready
);
   import cache_pkg::*;

   localparam int unsigned SETS   = 1 << INDEX_W;
   localparam int unsigned TAG_LO = INDEX_LSB + INDEX_W;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_sram_r_en;
   logic              r_sram_w_en;
   logic [SETS-1:0]   r_lru;          // 1 = way1 is the next victim

   logic               w_idle;
   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_off;
   logic               w_valid0, w_valid1;
   logic [TAG_W-1:0]   w_tag0, w_tag1;
   logic [63:0]        w_line0, w_line1, w_hit_line, w_wline;
   logic               w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
   logic               w_fill_done, w_wr_done;
   logic               w_line_we0, w_line_we1;
   logic [1:0]         w_word_sel, w_word_we0, w_word_we1;

   // In IDLE the live request is looked up; otherwise the captured one
   assign w_idle = (r_state == IDLE);
   assign w_idx  = w_idle ? address[INDEX_LSB +: INDEX_W] : r_addr[INDEX_LSB +: INDEX_W];
   assign w_tag  = w_idle ? address[TAG_LO +: TAG_W]      : r_addr[TAG_LO +: TAG_W];
   assign w_off  = w_idle ? address[OFF_BIT]              : r_addr[OFF_BIT];

   assign w_hit0     = w_valid0 && (w_tag0 == w_tag);
   assign w_hit1     = w_valid1 && (w_tag1 == w_tag);
   assign w_hit      = w_hit0 || w_hit1;
   assign w_hit_way  = !w_hit0;
   assign w_hit_line = w_hit0 ? w_line0 : w_line1;
   assign w_victim   = !w_valid0 ? 1'b0 : (!w_valid1 ? 1'b1 : r_lru[w_idx]);

   assign w_fill_done = (r_state == FILL) && sram_ready;
   assign w_wr_done   = (r_state == WRITE) && sram_ready && w_hit;
   assign w_word_sel  = w_off ? 2'b10 : 2'b01;
   assign w_line_we0  = w_fill_done && !w_victim;
   assign w_line_we1  = w_fill_done && w_victim;
   assign w_word_we0  = w_line_we0 ? 2'b11 : ((w_wr_done && !w_hit_way) ? w_word_sel : 2'b00);
   assign w_word_we1  = w_line_we1 ? 2'b11 : ((w_wr_done &&  w_hit_way) ? w_word_sel : 2'b00);
   assign w_wline     = (r_state == FILL) ? sram_rdata : {r_wdata, r_wdata};

   cache_set_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
      .clk       (clk),
      .rst       (rst),
      .i_index   (w_idx),
      .i_line_we (w_line_we0),
      .i_word_we (w_word_we0),
      .i_tag     (w_tag),
      .i_line    (w_wline),
      .o_valid   (w_valid0),
      .o_tag     (w_tag0),
      .o_line    (w_line0)
   );

   cache_set_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
      .clk       (clk),
      .rst       (rst),
      .i_index   (w_idx),
      .i_line_we (w_line_we1),
      .i_word_we (w_word_we1),
      .i_tag     (w_tag),
      .i_line    (w_wline),
      .o_valid   (w_valid1),
      .o_tag     (w_tag1),
      .o_line    (w_line1)
   );

   // Same-cycle completion: hits in IDLE, fill/write on the SRAM acknowledge
   always_comb begin
      ready = 1'b1;
      rdata = w_off ? w_hit_line[63:32] : w_hit_line[31:0];
      case (r_state)
         IDLE:    ready = !(mem_w_en || (mem_r_en && !w_hit));
         FILL: begin
            ready = sram_ready;
            rdata = w_off ? sram_rdata[63:32] : sram_rdata[31:0];
         end
         WRITE:   ready = sram_ready;
         default: ready = 1'b1;
      endcase
   end

   // Controller FSM, request capture, SRAM strobes and LRU maintenance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_sram_r_en <= 1'b0;
         r_sram_w_en <= 1'b0;
         r_lru       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (mem_w_en) begin
                  r_state     <= WRITE;
                  r_sram_w_en <= 1'b1;
                  r_addr      <= address;
                  r_wdata     <= wdata;
               end else if (mem_r_en) begin
                  if (w_hit) begin
                     r_lru[w_idx] <= !w_hit_way;
                  end else begin
                     r_state     <= FILL;
                     r_sram_r_en <= 1'b1;
                     r_addr      <= address;
                  end
               end
            end
            FILL: begin
               if (sram_ready) begin
                  r_state      <= IDLE;
                  r_sram_r_en  <= 1'b0;
                  r_lru[w_idx] <= !w_victim;
               end
            end
            WRITE: begin
               if (sram_ready) begin
                  r_state     <= IDLE;
                  r_sram_w_en <= 1'b0;
                  if (w_hit) begin
                     r_lru[w_idx] <= !w_hit_way;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sram_r_en    = r_sram_r_en;
   assign sram_w_en    = r_sram_w_en;
   assign sram_address = (r_state == FILL) ? {r_addr[ADDR_W-1:3], 3'b000} : r_addr;
   assign sram_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed and randomised checks of mem_cache_ctrl against hand values and a flat memory.
module tb_mem_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, wdata, rdata;
   logic        ready;
   logic        sram_r_en, sram_w_en;
   logic [31:0] sram_address, sram_wdata;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [512];

   localparam logic [63:0] L408 = 64'hAAAA_0002_BBBB_0001;

   mem_cache_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .address      (address),
      .wdata        (wdata),
      .rdata        (rdata),
      .ready        (ready),
      .sram_r_en    (sram_r_en),
      .sram_w_en    (sram_w_en),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered and left at posedge+1. mode 0: must hit, 1: must stall, 2: either.
   // lat = cycle after the request in which sram_ready is pulsed.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int mode, input int lat,
                         input logic [63:0] line, input logic [31:0] exp_rd,
                         input string tag);
      logic [31:0] exp_sa;
      bit          stalled;
      exp_sa   = wr ? a : {a[31:3], 3'b000};
      mem_r_en = rd;
      mem_w_en = wr;
      address  = a;
      wdata    = wd;
      #3;
      if (mode == 0)
         chk({tag, "_hit_ready"}, 64'(ready), 64'(1));
      else if (mode == 1 || wr)
         chk({tag, "_req_ready"}, 64'(ready), 64'(0));
      stalled = (ready !== 1'b1);
      if (!stalled && !wr)
         chk({tag, "_hit_rdata"}, 64'(rdata), 64'(exp_rd));
      if (stalled) begin
         for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            sram_ready = (n == lat);
            sram_rdata = line;
            #3;
            chk({tag, "_ready"}, 64'(ready), 64'(n == lat));
            chk({tag, "_sram_r_en"}, 64'(sram_r_en), 64'(rd && !wr));
            chk({tag, "_sram_w_en"}, 64'(sram_w_en), 64'(wr));
            if (n == 1) begin
               chk({tag, "_sram_addr"}, 64'(sram_address), 64'(exp_sa));
               if (wr) chk({tag, "_sram_wdata"}, 64'(sram_wdata), 64'(wd));
            end
            if (n == lat && !wr)
               chk({tag, "_fill_rdata"}, 64'(rdata), 64'(exp_rd));
         end
      end
      @(posedge clk); #1;
      sram_ready = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
   endtask

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rwd;
      logic [8:0]  wi;
      logic [7:0]  li;
      logic [63:0] rline;
      bit          rrd, rwr;
      int          rlat;

      rst        = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      address    = '0;
      wdata      = '0;
      sram_rdata = '0;
      sram_ready = 1'b0;
      for (int i = 0; i < 512; i++) model[i] = 32'hC0DE_0000 | 32'(i);

      #12;
      chk("rst_ready",     64'(ready),     64'(1));
      chk("rst_sram_r_en", 64'(sram_r_en), 64'(0));
      chk("rst_sram_w_en", 64'(sram_w_en), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // Cold miss with 4-cycle stall, then hits on both words of the line
      access(1, 0, 32'h408, 0, 1, 4, L408, 32'hBBBB_0001, "fill408");
      access(1, 0, 32'h408, 0, 0, 0, 0,    32'hBBBB_0001, "hit408");
      access(1, 0, 32'h40C, 0, 0, 0, 0,    32'hAAAA_0002, "hit40c");

      // Three lines into set 1: the third evicts the LRU way (0x408)
      access(1, 0, 32'h608, 0, 1, 2, 64'h6666_0004_6666_0000, 32'h6666_0000, "fill608");
      access(1, 0, 32'h808, 0, 1, 1, 64'h8888_0004_8888_0000, 32'h8888_0000, "fill808");
      access(1, 0, 32'h608, 0, 0, 0, 0,                       32'h6666_0000, "hit608");
      access(1, 0, 32'h408, 0, 1, 1, L408,                    32'hBBBB_0001, "refill408");
      access(1, 0, 32'h608, 0, 0, 0, 0,                       32'h6666_0000, "hit608b");

      // Write-through hit updates only the addressed word
      access(0, 1, 32'h40C, 32'h1234_5678, 1, 3, 0, 0,        "wr40c");
      access(1, 0, 32'h40C, 0, 0, 0, 0, 32'h1234_5678,        "hit40c_new");
      access(1, 0, 32'h408, 0, 0, 0, 0, 32'hBBBB_0001,        "hit408_kept");

      // Write miss does not allocate
      access(0, 1, 32'hC10, 32'hDEAD_BEEF, 1, 2, 0, 0,        "wr_c10");
      access(1, 0, 32'hC10, 0, 1, 1, 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF, "miss_c10");

      // Upper-word fill of an unaligned address (line address 0x018)
      access(1, 0, 32'h01C, 0, 1, 1, 64'h1111_0001_1111_0000, 32'h1111_0001, "fill01c");

      // Stray sram_ready in IDLE is ignored
      sram_ready = 1'b1;
      #3;
      chk("idle_ack_ready",     64'(ready),     64'(1));
      chk("idle_ack_sram_r_en", 64'(sram_r_en), 64'(0));
      @(posedge clk); #1;
      sram_ready = 1'b0;
      #3;
      chk("idle_after_r_en", 64'(sram_r_en), 64'(0));
      chk("idle_after_w_en", 64'(sram_w_en), 64'(0));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a fill
      mem_r_en = 1'b1;
      address  = 32'h028;
      #3;
      chk("rstfill_req_ready", 64'(ready), 64'(0));
      @(posedge clk); #1;
      chk("rstfill_r_en_on", 64'(sram_r_en), 64'(1));
      mem_r_en = 1'b0;
      rst      = 1'b0;
      #1;
      chk("rstfill_ready", 64'(ready),     64'(1));
      chk("rstfill_r_en",  64'(sram_r_en), 64'(0));
      chk("rstfill_w_en",  64'(sram_w_en), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      access(1, 0, 32'h408, 0, 1, 1, L408, 32'hBBBB_0001, "after_rst408");

      // Randomised loads/stores over 4 tags x 4 sets against the flat model
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 80; k++) begin
         ra    = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3)
               | (32'($urandom_range(0, 1)) << 2);
         wi    = ra[10:2];
         li    = ra[10:3];
         rwr   = ($urandom_range(0, 2) == 0);
         rrd   = !rwr || ($urandom_range(0, 7) == 0);
         rwd   = $urandom;
         rlat  = int'($urandom_range(1, 3));
         rline = {model[{li, 1'b1}], model[{li, 1'b0}]};
         access(rrd, rwr, ra, rwd, 2, rlat, rline, model[wi], "rnd");
         if (rwr) model[wi] = rwd;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
